mux4_rr_arbiter: RTL

Sequencing controller that shares a 4-to-1, WIDTH-bit selection datapath among four requesters. It arbitrates requests round-robin (or fixed-priority, see Configuration) and drives the 2-bit select `s` of an internal 4-to-1 mux. It presents the selected word on `f` with a valid/ready handshake and bounds each grant to HOLD transfers. It sits between the four word sources `w0..w3` and a single downstream consumer.

---
 rtl/mux_arb_pkg.sv | 26 ++
 rtl/mux4to1_sel.sv | 23 ++
 rtl/mux4_rr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and the arbitration search helper for the 4-source mux arbiter.
package mux_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Returns {found, idx}: the first requester at or after head, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] head);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        // Walk from the farthest offset back so the nearest match is kept last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = head + 2'(i);
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux4to1_sel.sv
// Purely combinational WIDTH-bit 4-to-1 word selector driven by a 2-bit select.
module mux4to1_sel #(
    parameter int WIDTH = 3
) (
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] w0,
    input  logic [WIDTH-1:0] w1,
    input  logic [WIDTH-1:0] w2,
    input  logic [WIDTH-1:0] w3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = w0;
        case (s)
            2'd0:    y = w0;
            2'd1:    y = w1;
            2'd2:    y = w2;
            default: y = w3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4-to-1 word mux among four requesters, with a
// per-grant transfer limit of HOLD. Define ARB_FIXED_PRIO_EN for fixed 0..3 priority.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] w0,
    input  logic [WIDTH-1:0] w1,
    input  logic [WIDTH-1:0] w2,
    input  logic [WIDTH-1:0] w3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] f,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

    arb_state_t       state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] mux_word;
    logic             xfer;
    logic             release_now;
    logic [3:0]       others;
    logic [1:0]       head_idle;
    logic [1:0]       head_rel;
    logic [2:0]       pick_idle;
    logic [2:0]       pick_rel;

`ifdef ARB_FIXED_PRIO_EN
    assign head_idle = 2'd0;
    assign head_rel  = 2'd0;
`else
    logic [1:0] ptr;
    assign head_idle = ptr;
    assign head_rel  = s + 2'd1;
`endif

    mux4to1_sel #(.WIDTH(WIDTH)) u_sel (
        .s  (s),
        .w0 (w0),
        .w1 (w1),
        .w2 (w2),
        .w3 (w3),
        .y  (mux_word)
    );

    assign busy        = (state == ST_GRANT);
    assign out_valid   = busy && req[s];
    assign f           = out_valid ? mux_word : '0;
    assign xfer        = out_valid && out_ready;
    assign release_now = busy && (!req[s] || (xfer && (cnt == CNT_LAST)));
    assign others      = req & ~(4'b0001 << s);

    // The released source sits last in the search order, so picking over the full
    // request vector only returns it when nobody else is asking.
    assign pick_idle = rr_pick(req, head_idle);
    assign pick_rel  = rr_pick(req, head_rel);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= 4'b0000;
            s     <= 2'd0;
            cnt   <= 4'd0;
`ifndef ARB_FIXED_PRIO_EN
            ptr   <= 2'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= 4'd0;
                    if (pick_idle[2]) begin
                        state <= ST_GRANT;
                        s     <= pick_idle[1:0];
                        gnt   <= 4'b0001 << pick_idle[1:0];
                    end else begin
                        gnt <= 4'b0000;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
`ifndef ARB_FIXED_PRIO_EN
                        ptr <= s + 2'd1;
`endif
                        cnt <= 4'd0;
                        // Hand over on the same edge when someone else is waiting.
                        if (|others) begin
                            s   <= pick_rel[1:0];
                            gnt <= 4'b0001 << pick_rel[1:0];
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= 4'b0000;
                        end
                    end else if (xfer) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

endmodule
